// File: rtl/uart_cmd_assembler_pkg.sv
// Shared types and constants for the UART command assembler.
package uart_cmd_assembler_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CMD_W  = 16;

    localparam logic [BYTE_W-1:0] POS_ACK = 8'hA5;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_cmd_assembler_if.sv
// Bundle between UART RX/TX, cmd_proc and the command assembler.
interface uart_cmd_assembler_if;
    import uart_cmd_assembler_pkg::*;

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_rdy;
    logic              clr_rx_rdy;
    logic [CMD_W-1:0]  cmd;
    logic              cmd_rdy;
    logic              clr_cmd_rdy;
    logic [BYTE_W-1:0] resp;
    logic              send_resp;
    logic [BYTE_W-1:0] tx_data;
    logic              trmt;
    logic              tx_done;
    logic              frame_err;
    logic              overrun;
    logic              resp_drop;

    // Assembler side
    modport slave (
        input  rx_byte, rx_rdy, clr_cmd_rdy, resp, send_resp, tx_done,
        output clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, frame_err, overrun, resp_drop
    );

    // UART / cmd_proc side
    modport master (
        output rx_byte, rx_rdy, clr_cmd_rdy, resp, send_resp, tx_done,
        input  clr_rx_rdy, cmd, cmd_rdy, tx_data, trmt, frame_err, overrun, resp_drop
    );

endinterface

// File: rtl/uart_cmd_assembler.sv
// Packs two UART bytes into a 16-bit command with gap timeout, and forwards
// cmd_proc responses to UART TX through a one-entry pending buffer.
module uart_cmd_assembler
    import uart_cmd_assembler_pkg::*;
#(
    parameter int unsigned GAP_TIMEOUT = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_cmd_assembler_if.slave  bus
);

    localparam int unsigned      TMR_W    = $clog2(GAP_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_TIMEOUT - 1);

    rx_state_t         state_q, state_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_rdy_q, cmd_rdy_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              trmt_q, trmt_d;
    logic              tx_busy_q, tx_busy_d;
    logic [BYTE_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic              resp_drop_q, resp_drop_d;
    logic              busy_eff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= WAIT_HI;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            timer_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_data_q   <= '0;
            trmt_q      <= 1'b0;
            tx_busy_q   <= 1'b0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            resp_drop_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            timer_q     <= timer_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            tx_data_q   <= tx_data_d;
            trmt_q      <= trmt_d;
            tx_busy_q   <= tx_busy_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            resp_drop_q <= resp_drop_d;
        end
    end

    // RX byte pairing; a completed command overrides a same-cycle clear
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_rdy_d   = cmd_rdy_q & ~bus.clr_cmd_rdy;
        timer_d     = timer_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            WAIT_HI: begin
                if (bus.rx_rdy) begin
                    cmd_d[CMD_W-1:BYTE_W] = bus.rx_byte;
                    timer_d               = '0;
                    cmd_rdy_d             = 1'b0;
                    overrun_d             = cmd_rdy_q;
                    state_d               = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (bus.rx_rdy) begin
                    cmd_d[BYTE_W-1:0] = bus.rx_byte;
                    cmd_rdy_d         = 1'b1;
                    state_d           = WAIT_HI;
                end else if (timer_q == TMR_LAST) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_HI;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    // TX forwarding; a tx_done frees both the transmitter and the pending slot
    always_comb begin
        tx_data_d   = tx_data_q;
        trmt_d      = 1'b0;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        resp_drop_d = 1'b0;
        busy_eff    = tx_busy_q & ~bus.tx_done;
        if (bus.tx_done && pend_v_q) begin
            tx_data_d = pend_q;
            trmt_d    = 1'b1;
            pend_v_d  = 1'b0;
        end
        if (bus.send_resp) begin
            if (!busy_eff && !pend_v_q) begin
                tx_data_d = bus.resp;
                trmt_d    = 1'b1;
            end else if (!pend_v_q || bus.tx_done) begin
                pend_d   = bus.resp;
                pend_v_d = 1'b1;
            end else begin
                resp_drop_d = 1'b1;
            end
        end
        tx_busy_d = trmt_d | busy_eff;
    end

    assign bus.clr_rx_rdy = bus.rx_rdy;
    assign bus.cmd        = cmd_q;
    assign bus.cmd_rdy    = cmd_rdy_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.trmt       = trmt_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.resp_drop  = resp_drop_q;

endmodule
